// File: rtl/sys_defs.sv
// Shared definitions for the FU-to-complete path: packet types, FU count, FU index map.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sys_defs;

  localparam int NUM_FU = 8;
  localparam int XLEN   = 32;
  localparam int PR_W   = 6;   // physical register tag width
  localparam int ROB_W  = 5;   // ROB entry index width

  // FU index to FU_STATE_PACKET field mapping (index == bit position).
  localparam int FU_ALU_1  = 0;
  localparam int FU_ALU_2  = 1;
  localparam int FU_ALU_3  = 2;
  localparam int FU_BRANCH = 3;
  localparam int FU_MULT_1 = 4;
  localparam int FU_MULT_2 = 5;
  localparam int FU_LS_1   = 6;
  localparam int FU_LS_2   = 7;

  typedef struct packed {
    logic             valid;
    logic [PR_W-1:0]  dest_pr;
    logic [XLEN-1:0]  dest_value;
    logic [ROB_W-1:0] rob_entry;
    logic [XLEN-1:0]  target_pc;
    logic             if_take_branch;
  } FU_COMPLETE_PACKET;

  // Last member is bit 0, so alu_1 lands on bit 0.
  typedef struct packed {
    logic ls_2;
    logic ls_1;
    logic mult_2;
    logic mult_1;
    logic branch;
    logic alu_3;
    logic alu_2;
    logic alu_1;
  } FU_STATE_PACKET;

endpackage

// File: rtl/fu_result_fifo.sv
// Single-channel DEPTH-entry result FIFO with push, pop, synchronous flush, count, head and ready.
// Latency: a push is visible at the head one cycle later; no bypass.
// Backpressure: ready = count < DEPTH, from registered count only; pushes while not ready are the caller's problem.
//
// Ports: clock/reset (async active-low), push/push_dat, pop, flush,
//        ready, count, head_dat (undefined content when count == 0).
module fu_result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [WIDTH-1:0]           head_dat
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pop on an empty FIFO is ignored so pointers never run ahead.
  logic pop_eff;
  assign pop_eff  = pop && (count != '0);
  assign ready    = (count < CNT_W'(DEPTH));
  assign head_dat = mem[head];

  // Storage is not reset; the owner masks the head while empty.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem[tail] <= push_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)    tail <= tail + 1'b1;
      if (pop_eff) head <= head + 1'b1;
      case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fu_complete_buffer.sv
// Per-FU result holding buffer feeding the complete stage; one private FIFO per FU.
// Latency: push in cycle N is presented as finish/fu_c_in in cycle N+1.
// Backpressure: fu_ready[i] from registered count only; fu_c_stall[i] holds channel i's head.
//
// Ports: clock, reset (async active-low), fu_valid/fu_pkt/fu_ready (FU side),
//        squash (flush all), fu_finish/fu_c_in/fu_c_stall (complete side),
//        occupancy (registered total of all channel counts).
module fu_complete_buffer
  import sys_defs::*;
#(
  parameter int NUM_FU = sys_defs::NUM_FU,
  parameter int DEPTH  = 2
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_FU-1:0]                      fu_valid,
  input  FU_COMPLETE_PACKET [NUM_FU-1:0]         fu_pkt,
  output logic [NUM_FU-1:0]                      fu_ready,
  input  logic                                   squash,
  output FU_STATE_PACKET                         fu_finish,
  output FU_COMPLETE_PACKET [NUM_FU-1:0]         fu_c_in,
  input  FU_STATE_PACKET                         fu_c_stall,
  output logic [$clog2(NUM_FU*DEPTH+1)-1:0]      occupancy
);

  localparam int PKT_W = $bits(FU_COMPLETE_PACKET);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OCC_W = $clog2(NUM_FU*DEPTH+1);

  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] finish_vec;
  logic [NUM_FU-1:0] stall_vec;
  logic [PKT_W-1:0]  head_dat [NUM_FU];
  logic [CNT_W-1:0]  count    [NUM_FU];

  assign stall_vec = fu_c_stall;
  assign fu_finish = FU_STATE_PACKET'(finish_vec);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_chan
    assign finish_vec[i] = (count[i] != '0);
    assign push[i]       = fu_valid[i] & fu_ready[i];
    assign pop[i]        = finish_vec[i] & ~stall_vec[i];

    fu_result_fifo #(
      .WIDTH (PKT_W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push[i]),
      .push_dat (fu_pkt[i]),
      .pop      (pop[i]),
      .flush    (squash),
      .ready    (fu_ready[i]),
      .count    (count[i]),
      .head_dat (head_dat[i])
    );

    // Empty channels present an all-zero packet so stale storage never leaks.
    always_comb begin
      fu_c_in[i] = '0;
      if (finish_vec[i]) begin
        fu_c_in[i]       = FU_COMPLETE_PACKET'(head_dat[i]);
        fu_c_in[i].valid = 1'b1;
      end
    end
  end

  // Occupancy tracks the sum of counts incrementally, mirroring each channel's update.
  logic [OCC_W-1:0] occ_next;

  always_comb begin
    occ_next = occupancy;
    for (int i = 0; i < NUM_FU; i++) begin
      occ_next = occ_next + OCC_W'(push[i]) - OCC_W'(pop[i]);
    end
    if (squash) begin
      occ_next = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

endmodule

// File: tb/tb_fu_complete_buffer.sv
// Directed self-checking bench for fu_complete_buffer.
// Latency: n/a.
// Backpressure: n/a.
module tb_fu_complete_buffer;
  import sys_defs::*;

  localparam int OCC_W = $clog2(NUM_FU*2+1);

  logic                           clock;
  logic                           reset;
  logic [NUM_FU-1:0]              fu_valid;
  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_pkt;
  logic [NUM_FU-1:0]              fu_ready;
  logic                           squash;
  FU_STATE_PACKET                 fu_finish;
  FU_COMPLETE_PACKET [NUM_FU-1:0] fu_c_in;
  FU_STATE_PACKET                 fu_c_stall;
  logic [OCC_W-1:0]               occupancy;

  logic [7:0] fin_v;
  assign fin_v = fu_finish;

  int checks   = 0;
  int failures = 0;

  fu_complete_buffer #(.NUM_FU(NUM_FU), .DEPTH(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .fu_valid   (fu_valid),
    .fu_pkt     (fu_pkt),
    .fu_ready   (fu_ready),
    .squash     (squash),
    .fu_finish  (fu_finish),
    .fu_c_in    (fu_c_in),
    .fu_c_stall (fu_c_stall),
    .occupancy  (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic FU_COMPLETE_PACKET mk(input logic [5:0] pr, input logic [31:0] v,
                                           input logic [4:0] rob);
    FU_COMPLETE_PACKET p;
    p            = '0;
    p.valid      = 1'b1;
    p.dest_pr    = pr;
    p.dest_value = v;
    p.rob_entry  = rob;
    return p;
  endfunction

  initial begin
    reset      = 1'b0;
    fu_valid   = '0;
    fu_pkt     = '0;
    squash     = 1'b0;
    fu_c_stall = '0;

    // Reset state
    #12;
    check("rst_finish", fin_v, 8'h00);
    check("rst_ready", fu_ready, 8'hFF);
    check("rst_occ", occupancy, 0);
    check("rst_cin_zero", |fu_c_in, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // 1: single push, one-cycle latency, immediate drain
    fu_valid[0] = 1'b1;
    fu_pkt[0]   = mk(6'h01, 32'h12345678, 5'd10);
    tick();
    fu_valid = '0;
    check("t1_alu_1", fu_finish.alu_1, 1'b1);
    check("t1_finish", fin_v, 8'h01);
    check("t1_value", fu_c_in[0].dest_value, 32'h12345678);
    check("t1_rob", fu_c_in[0].rob_entry, 5'd10);
    check("t1_valid", fu_c_in[0].valid, 1'b1);
    check("t1_occ", occupancy, 1);
    tick();
    check("t1_finish_after", fin_v, 8'h00);
    check("t1_occ_after", occupancy, 0);
    check("t1_cin_empty", fu_c_in[0], 0);

    // 2/3: stall channel 0, fill it, FU holds 0xC
    fu_c_stall = FU_STATE_PACKET'(8'h01);
    fu_valid[0] = 1'b1;
    fu_pkt[0]   = mk(6'h02, 32'hA, 5'd1);
    tick();
    check("t2_ready_1", fu_ready[0], 1'b1);
    fu_pkt[0] = mk(6'h03, 32'hB, 5'd2);
    tick();
    check("t2_ready_full", fu_ready[0], 1'b0);
    check("t2_occ_full", occupancy, 2);
    fu_pkt[0] = mk(6'h04, 32'hC, 5'd3);
    tick();
    check("t2_held_occ", occupancy, 2);
    check("t2_head_A", fu_c_in[0].dest_value, 32'hA);
    // Release stall while fu_valid is high at full: pop only
    fu_c_stall = '0;
    tick();
    check("t3_pop_only_occ", occupancy, 1);
    check("t3_head_B", fu_c_in[0].dest_value, 32'hB);
    check("t3_ready_rise", fu_ready[0], 1'b1);
    // count 1, push C and pop B together
    tick();
    fu_valid = '0;
    check("t3_pushpop_occ", occupancy, 1);
    check("t3_head_C", fu_c_in[0].dest_value, 32'hC);
    tick();
    check("t3_drained", fin_v, 8'h00);

    // 4: fill ch0=2, ch7=2, ch3=1, then squash with push on ch3
    fu_c_stall = FU_STATE_PACKET'(8'hFF);
    fu_valid = 8'b1000_1001;
    fu_pkt[0] = mk(6'h10, 32'h100, 5'd0);
    fu_pkt[3] = mk(6'h13, 32'h103, 5'd3);
    fu_pkt[7] = mk(6'h17, 32'h107, 5'd7);
    tick();
    fu_valid = 8'b1000_0001;
    tick();
    check("t4_occ5", occupancy, 5);
    check("t4_finish", fin_v, 8'h89);
    check("t4_ready", fu_ready, 8'b0111_1110);
    squash    = 1'b1;
    fu_valid  = 8'b0000_1000;
    fu_pkt[3] = mk(6'h2D, 32'hDEAD, 5'd13);
    tick();
    squash   = 1'b0;
    fu_valid = '0;
    check("t4_sq_occ", occupancy, 0);
    check("t4_sq_finish", fin_v, 8'h00);
    check("t4_sq_cin3", fu_c_in[3], 0);
    check("t4_sq_ready", fu_ready, 8'hFF);
    tick();
    check("t4_sq_never", fin_v, 8'h00);

    // 5: asynchronous reset mid-stream at occupancy 4
    fu_valid = 8'b0011_0110;
    tick();
    fu_valid = '0;
    check("t5_occ4", occupancy, 4);
    #2;
    reset = 1'b0;
    #1;
    check("t5_rst_finish", fin_v, 8'h00);
    check("t5_rst_cin", |fu_c_in, 1'b0);
    check("t5_rst_ready", fu_ready, 8'hFF);
    check("t5_rst_occ", occupancy, 0);
    @(negedge clock);
    reset      = 1'b1;
    fu_c_stall = '0;
    fu_valid[2] = 1'b1;
    fu_pkt[2]   = mk(6'h22, 32'h55, 5'd4);
    tick();
    fu_valid = '0;
    check("t5_lat_finish", fin_v, 8'h04);
    check("t5_lat_value", fu_c_in[2].dest_value, 32'h55);
    tick();
    check("t5_lat_drain", occupancy, 0);

    // 6: all channels at once, odd channels stalled for 3 edges
    fu_c_stall = FU_STATE_PACKET'(8'hAA);
    fu_valid   = 8'hFF;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_pkt[i] = mk(6'(i), 32'h200 + 32'(i), 5'(i));
    end
    tick();
    fu_valid = '0;
    check("t6_occ8", occupancy, 8);
    check("t6_finish_all", fin_v, 8'hFF);
    for (int i = 0; i < NUM_FU; i++) begin
      check($sformatf("t6_rob_%0d", i), fu_c_in[i].rob_entry, 64'(i));
    end
    tick();
    check("t6_occ4", occupancy, 4);
    check("t6_finish_odd", fin_v, 8'hAA);
    check("t6_rob_7_held", fu_c_in[7].rob_entry, 5'd7);
    tick();
    tick();
    check("t6_occ4_hold", occupancy, 4);
    fu_c_stall = '0;
    tick();
    check("t6_occ0", occupancy, 0);
    check("t6_finish_none", fin_v, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fu_complete_buffer.md
Name: fu_complete_buffer

Overview:
Per-FU result holding buffer between the functional units and the complete stage. Each FU pushes its finished result into a small private FIFO. The buffer presents each FIFO head to the complete stage as that FU's finish request plus completion packet, and pops the head only when the complete stage does not stall that FU. A branch-mispredict squash flushes every channel, so that no stale result reaches the CDB.

Parameters:
NUM_FU, 8, number of FU channels; index order matches the FU_STATE_PACKET bit order (alu_1 = bit 0).
DEPTH, 2, entries per channel FIFO; power of two, at least 2.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
fu_valid  input  NUM_FU  FU i has a result to push this cycle.
fu_pkt  input  NUM_FU x FU_COMPLETE_PACKET  result from FU i.
fu_ready  output  NUM_FU  channel i can accept a push this cycle.
squash  input  1  mispredict flush.
fu_finish  output  FU_STATE_PACKET  bit i is set when channel i is non-empty.
fu_c_in  output  NUM_FU x FU_COMPLETE_PACKET  head entry of channel i.
fu_c_stall  input  FU_STATE_PACKET  bit i means the complete stage refuses channel i this cycle.
occupancy  output  $clog2(NUM_FU*DEPTH+1)  total number of buffered entries.

Behaviour:
- Per channel state:
  - storage of DEPTH packets;
  - head and tail pointers, log2(DEPTH) bits each, which wrap modulo DEPTH;
  - a count from 0 to DEPTH.
- fu_ready[i] = (count_i < DEPTH). It depends on the registered count only; it must not depend on a same-cycle pop or on fu_c_stall (no combinational path from the complete stage to the FUs).
- push_i = fu_valid[i] & fu_ready[i]. The packet is written at the tail. fu_valid while not ready is ignored, and the FU must hold its result.
- fu_finish[i] = (count_i != 0).
- fu_c_in[i]:
  - non-empty channel: the head packet, with .valid forced to 1;
  - empty channel: all-zero packet.
- pop_i = fu_finish[i] & ~fu_c_stall[i]. A stall bit on an empty channel has no effect.
- Push and pop in the same cycle on a channel: both pointers advance and the count is unchanged. This is legal at count == DEPTH only if ready was already high, which it is not, so at full only a pop occurs.
- Latency: a push in cycle N makes the entry visible on fu_c_in and fu_finish in cycle N+1. There is no same-cycle bypass.
- Ordering: strict FIFO within a channel. There is no ordering across channels; cross-channel arbitration belongs to the complete stage.
- squash (synchronous, highest priority):
  - next cycle every count, head and tail is 0;
  - same-cycle pushes are dropped;
  - same-cycle pops are irrelevant.
  - fu_ready stays as computed during the squash cycle.
- occupancy = sum of all counts, registered, consistent with the counts of the same cycle.
- Reset (asserted low at any time, including mid-operation): all counts and pointers go to 0 immediately.
  - Outputs during reset: fu_finish = 0, fu_c_in all zero, fu_ready all ones, occupancy = 0.
  - Storage contents need no reset, but must never be visible while the channel is empty.
- No X propagation: outputs come from registered state only, plus muxing on the head pointer.

Decomposition:
- Shared package (sys_defs):
  - FU_COMPLETE_PACKET (valid, dest_pr, dest_value, rob_entry, target_pc, if_take_branch);
  - FU_STATE_PACKET;
  - the NUM_FU constant;
  - the FU-index-to-field mapping.
- One sub-module: fu_result_fifo. It is a single-channel DEPTH-entry FIFO with push, pop, flush, count, head data and ready. It is instantiated NUM_FU times by generate. The top level does only the packet mux and the occupancy adder.

Test Plan:
1. Release reset, then fu_valid[0]=1 with dest_pr=0x01, dest_value=0x12345678, rob_entry=10 for 1 cycle, and fu_c_stall=0.
   - Next cycle: fu_finish.alu_1=1 and fu_c_in[0].dest_value=0x12345678.
   - Following cycle: fu_finish=0 and occupancy=0.
2. fu_c_stall.alu_1 held at 1; push 3 results (values 0xA, 0xB, 0xC) on channel 0.
   - fu_ready[0] drops after the 2nd push, and 0xC is held off by the FU.
   - Release the stall: the complete stage sees 0xA, then 0xB, then 0xC in order.
3. Full channel (count=2, stall on), then release the stall and assert fu_valid in the same cycle.
   - Only a pop occurs; count becomes 1; ready rises next cycle.
   - At count=1 with push and pop together, count stays 1.
4. Fill channels 0, 3 and 7 (occupancy=5), then assert squash together with a push on channel 3.
   - Next cycle: occupancy=0, fu_finish=0, and the pushed entry never appears.
5. Assert reset low mid-stream with occupancy=4.
   - Immediately: fu_finish=0, fu_c_in all zero, fu_ready=all ones.
   - After release: first push latency is 1 cycle.
6. Push every channel in the same cycle with distinct rob_entry 0..7, stall odd channels for 3 cycles.
   - Even channels drain after 1 cycle; odd channels drain after the stall releases; occupancy steps 8 → 4 → 0.
